uart_term_cmd_ctrl: RTL and testbench
=====================================

// Module: uart_term_cmd_ctrl
// PURPOSE
//  Terminal command sequencer between the uart_io byte datapath and the C2F fabric port of the UART tile.
//  Parses host frames 'W'+ADDR[4]+DATA[4] and 'R'+ADDR[4], received MSB byte first.
//  Issues the matching fabric request, waits for the read response and streams the read data back to the host.
//  Owns C2F request sequencing: only one request is outstanding at any time.
// PARAMETERS
//  THREAD_ID    2'd0     thread ID driven on every request; responses with any other TID are dropped
//  RSP_TMO_CYC  100000   QClk cycles to wait for RD_RSP before abandoning the read
//  BYTE_TMO_CYC 50000    QClk cycles allowed between frame bytes (used only with UART_CMD_BYTE_TMO_EN)
// PORTS
//  QClk                 in   1   clock
//  RstQnnnH             in   1   synchronous reset, active high
//  RxByteValid          in   1   one-cycle pulse: new byte from UART RX
//  RxByte               in   8   received byte
//  TxByteValid          out  1   byte to UART TX is valid; held until TxByteReady
//  TxByte               out  8   byte to transmit
//  TxByteReady          in   1   UART TX accepts the byte this cycle
//  C2F_ReqValidQ500H    out  1   fabric request valid; held until C2F_ReqReadyQ500H
//  C2F_ReqReadyQ500H    in   1   fabric accepts the request this cycle
//  C2F_ReqOpcodeQ500H   out  t_opcode  WR or RD
//  C2F_ReqAddressQ500H  out  32  assembled address
//  C2F_ReqDataQ500H     out  32  assembled data (0 for RD)
//  C2F_ReqThreadIDQ500H out  2   THREAD_ID
//  F2C_RspValidQ502H    in   1   response valid
//  F2C_RspOpcodeQ502H   in   t_opcode  RD_RSP expected
//  F2C_RspThreadIDQ502H in   2   response TID
//  F2C_RspDataQ502H     in   32  read data
//  CmdErr               out  1   sticky: bad command byte or response timeout; cleared by reset only
// BEHAVIOUR
//  Reset
//   - All outputs 0; FSM in IDLE; byte counter 0; address/data shift registers 0.
//  FSM states
//   - IDLE
//     - 0x57 ('W'): go to ADDR, op=WR.
//     - 0x52 ('R'): go to ADDR, op=RD.
//     - Any other byte: set CmdErr, stay in IDLE.
//   - ADDR: shift in 4 bytes, addr={addr[23:0],RxByte}. After the 4th byte go to DATA if WR, else ISSUE.
//   - DATA: shift in 4 bytes the same way, then go to ISSUE.
//   - ISSUE
//     - ReqValid asserts the cycle after the last frame byte.
//     - ReqValid and all Req fields are held stable until ReqReady.
//     - On handshake: WR returns to IDLE (posted write, no host reply); RD goes to WAIT_RSP.
//   - WAIT_RSP
//     - Accept F2C_RspValid only when opcode==RD_RSP and TID==THREAD_ID; latch the data and go to TX.
//     - Non-matching responses are ignored.
//     - After RSP_TMO_CYC cycles: set CmdErr, go to IDLE.
//   - TX
//     - Send 4 bytes, data[31:24] first.
//     - Advance one byte per TxByteValid&TxByteReady; after the 4th byte go to IDLE.
//  Frame bytes
//   - RxByteValid in ISSUE/WAIT_RSP/TX is dropped; no buffering, and CmdErr is not set.
//   - Byte counter is 2 bits: wraps 3->0 on the final byte of each field.
//  Latency and reset
//   - Minimum latency from last RX byte to ReqValid: 1 cycle.
//   - Minimum latency from RD_RSP to TxByteValid: 1 cycle.
//   - Reset in any state aborts the sequence immediately; no partial request or byte is emitted afterwards.
//  Timeout counters
//   - Counter width is $clog2 of the largest timeout parameter + 1.
//   - Counters saturate and never wrap.
// CONFIGURATION
//  UART_CMD_BYTE_TMO_EN defined
//   - In ADDR/DATA, the gap counter reloads on every RxByteValid.
//   - If the gap reaches BYTE_TMO_CYC: discard the partial frame, set CmdErr, return to IDLE.
//  UART_CMD_BYTE_TMO_EN undefined
//   - No gap counter; the FSM waits indefinitely for the remaining frame bytes.
// STRUCTURE
//  lotr_pkg
//   - Add t_uart_cmd_state enum {IDLE,ADDR,DATA,ISSUE,WAIT_RSP,TX}.
//   - Add constants UART_CMD_WR=8'h57 and UART_CMD_RD=8'h52.
//   - Reuse the existing t_opcode.
//  Sub-module uart_cmd_timer
//   - Loadable saturating down-counter with an expire flag.
//   - One instance is used for the response timeout.
//   - A second instance exists only under UART_CMD_BYTE_TMO_EN.
// TESTING
//  1. Frame 57 00 00 10 04 DE AD BE EF, ReqReady=1.
//     -> one WR request, addr 0x00001004, data 0xDEADBEEF, TID THREAD_ID; no TX bytes.
//  2. Frame 52 00 00 20 00, ReqReady held low 5 cycles.
//     -> RD request held stable for 5 cycles, handshake on cycle 6.
//     Then RD_RSP data 0x12345678 -> TX bytes 12,34,56,78 in order.
//  3. TxByteReady toggling 1/0 during test 2.
//     -> each byte held until accepted; no byte lost or duplicated.
//  4. Byte 0x41 in IDLE.
//     -> CmdErr=1, no request.
//     Then a valid 'R' frame still completes normally.
//  5. RD issued, response with wrong TID, then no response.
//     -> wrong-TID response ignored; CmdErr set after RSP_TMO_CYC; FSM returns to IDLE.
//  6. Reset asserted after the 3rd address byte, then a full 'W' frame.
//     -> no request from the aborted frame; the new frame decodes correctly.
//     With UART_CMD_BYTE_TMO_EN: stall mid-frame beyond BYTE_TMO_CYC -> CmdErr=1, FSM back to IDLE.

Source files
------------

// File: rtl/lotr_pkg.sv
// Shared UART tile types: fabric opcodes and the terminal command sequencer state/constants.
package lotr_pkg;

  typedef enum logic [1:0] {
    NOP    = 2'd0,
    WR     = 2'd1,
    RD     = 2'd2,
    RD_RSP = 2'd3
  } t_opcode;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    ISSUE,
    WAIT_RSP,
    TX
  } t_uart_cmd_state;

  localparam logic [7:0] UART_CMD_WR = 8'h57;
  localparam logic [7:0] UART_CMD_RD = 8'h52;

endpackage

// File: rtl/uart_cmd_timer.sv
// Loadable saturating down-counter; expired is high whenever the count sits at zero.
module uart_cmd_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             expired
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/uart_term_cmd_ctrl.sv
// Host terminal command sequencer: 'W'/'R' frames to C2F requests, read data streamed back on TX.
// Optional inter-byte frame timeout enabled by defining UART_CMD_BYTE_TMO_EN.
module uart_term_cmd_ctrl
  import lotr_pkg::*;
#(
  parameter logic [1:0]  THREAD_ID    = 2'd0,
  parameter int unsigned RSP_TMO_CYC  = 100000,
  parameter int unsigned BYTE_TMO_CYC = 50000
) (
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic        RxByteValid,
  input  logic [7:0]  RxByte,
  output logic        TxByteValid,
  output logic [7:0]  TxByte,
  input  logic        TxByteReady,
  output logic        C2F_ReqValidQ500H,
  input  logic        C2F_ReqReadyQ500H,
  output t_opcode     C2F_ReqOpcodeQ500H,
  output logic [31:0] C2F_ReqAddressQ500H,
  output logic [31:0] C2F_ReqDataQ500H,
  output logic [1:0]  C2F_ReqThreadIDQ500H,
  input  logic        F2C_RspValidQ502H,
  input  t_opcode     F2C_RspOpcodeQ502H,
  input  logic [1:0]  F2C_RspThreadIDQ502H,
  input  logic [31:0] F2C_RspDataQ502H,
  output logic        CmdErr
);

  localparam int unsigned MaxTmo = (RSP_TMO_CYC > BYTE_TMO_CYC) ? RSP_TMO_CYC : BYTE_TMO_CYC;
  localparam int unsigned TmoW   = $clog2(MaxTmo) + 1;

  t_uart_cmd_state state;
  logic [1:0]      byte_cnt;
  logic [23:0]     tx_sh;
  logic            rsp_load;
  logic            rsp_tmo;
  logic            rsp_hit;

  assign rsp_load = (state == ISSUE) && C2F_ReqReadyQ500H && (C2F_ReqOpcodeQ500H == RD);
  assign rsp_hit  = F2C_RspValidQ502H && (F2C_RspOpcodeQ502H == RD_RSP) &&
                    (F2C_RspThreadIDQ502H == THREAD_ID);

  uart_cmd_timer #(
    .Width(TmoW)
  ) u_rsp_timer (
    .clk     (QClk),
    .rst     (RstQnnnH),
    .load    (rsp_load),
    .load_val(TmoW'(RSP_TMO_CYC)),
    .expired (rsp_tmo)
  );

`ifdef UART_CMD_BYTE_TMO_EN
  logic byte_tmo;

  // Reloads on every received byte, so it measures the gap since the last one.
  uart_cmd_timer #(
    .Width(TmoW)
  ) u_byte_timer (
    .clk     (QClk),
    .rst     (RstQnnnH),
    .load    (RxByteValid),
    .load_val(TmoW'(BYTE_TMO_CYC)),
    .expired (byte_tmo)
  );
`endif

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      state                <= IDLE;
      byte_cnt             <= 2'd0;
      tx_sh                <= 24'd0;
      TxByteValid          <= 1'b0;
      TxByte               <= 8'd0;
      C2F_ReqValidQ500H    <= 1'b0;
      C2F_ReqOpcodeQ500H   <= NOP;
      C2F_ReqAddressQ500H  <= 32'd0;
      C2F_ReqDataQ500H     <= 32'd0;
      C2F_ReqThreadIDQ500H <= 2'd0;
      CmdErr               <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (RxByteValid) begin
            byte_cnt <= 2'd0;
            if (RxByte == UART_CMD_WR) begin
              state              <= ADDR;
              C2F_ReqOpcodeQ500H <= WR;
            end else if (RxByte == UART_CMD_RD) begin
              state              <= ADDR;
              C2F_ReqOpcodeQ500H <= RD;
              C2F_ReqDataQ500H   <= 32'd0;
            end else begin
              CmdErr <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (RxByteValid) begin
            C2F_ReqAddressQ500H <= {C2F_ReqAddressQ500H[23:0], RxByte};
            byte_cnt            <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (C2F_ReqOpcodeQ500H == WR) begin
                state <= DATA;
              end else begin
                state                <= ISSUE;
                C2F_ReqValidQ500H    <= 1'b1;
                C2F_ReqThreadIDQ500H <= THREAD_ID;
              end
            end
          end
`ifdef UART_CMD_BYTE_TMO_EN
          else if (byte_tmo) begin
            state  <= IDLE;
            CmdErr <= 1'b1;
          end
`endif
        end
        DATA: begin
          if (RxByteValid) begin
            C2F_ReqDataQ500H <= {C2F_ReqDataQ500H[23:0], RxByte};
            byte_cnt         <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state                <= ISSUE;
              C2F_ReqValidQ500H    <= 1'b1;
              C2F_ReqThreadIDQ500H <= THREAD_ID;
            end
          end
`ifdef UART_CMD_BYTE_TMO_EN
          else if (byte_tmo) begin
            state  <= IDLE;
            CmdErr <= 1'b1;
          end
`endif
        end
        ISSUE: begin
          if (C2F_ReqReadyQ500H) begin
            C2F_ReqValidQ500H <= 1'b0;
            state             <= (C2F_ReqOpcodeQ500H == WR) ? IDLE : WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A matching response wins over a timeout expiring in the same cycle.
          if (rsp_hit) begin
            TxByteValid <= 1'b1;
            TxByte      <= F2C_RspDataQ502H[31:24];
            tx_sh       <= F2C_RspDataQ502H[23:0];
            byte_cnt    <= 2'd0;
            state       <= TX;
          end else if (rsp_tmo) begin
            CmdErr <= 1'b1;
            state  <= IDLE;
          end
        end
        TX: begin
          if (TxByteReady) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              TxByteValid <= 1'b0;
              state       <= IDLE;
            end else begin
              TxByte <= tx_sh[23:16];
              tx_sh  <= {tx_sh[15:0], 8'd0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_term_cmd_ctrl.sv
// Randomized self-checking bench for uart_term_cmd_ctrl; covers UART_CMD_BYTE_TMO_EN when defined.
module tb_uart_term_cmd_ctrl;
  import lotr_pkg::*;

  localparam int unsigned RspTmo  = 60;
  localparam int unsigned ByteTmo = 30;
  localparam logic [1:0]  Tid     = 2'd2;

  logic        clk;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        tx_ready;
  logic        req_valid;
  logic        req_ready;
  t_opcode     req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_tid;
  logic        rsp_valid;
  t_opcode     rsp_op;
  logic [1:0]  rsp_tid;
  logic [31:0] rsp_data;
  logic        cmd_err;

  uart_term_cmd_ctrl #(
    .THREAD_ID   (Tid),
    .RSP_TMO_CYC (RspTmo),
    .BYTE_TMO_CYC(ByteTmo)
  ) dut (
    .QClk                (clk),
    .RstQnnnH            (rst),
    .RxByteValid         (rx_valid),
    .RxByte              (rx_byte),
    .TxByteValid         (tx_valid),
    .TxByte              (tx_byte),
    .TxByteReady         (tx_ready),
    .C2F_ReqValidQ500H   (req_valid),
    .C2F_ReqReadyQ500H   (req_ready),
    .C2F_ReqOpcodeQ500H  (req_op),
    .C2F_ReqAddressQ500H (req_addr),
    .C2F_ReqDataQ500H    (req_data),
    .C2F_ReqThreadIDQ500H(req_tid),
    .F2C_RspValidQ502H   (rsp_valid),
    .F2C_RspOpcodeQ502H  (rsp_op),
    .F2C_RspThreadIDQ502H(rsp_tid),
    .F2C_RspDataQ502H    (rsp_data),
    .CmdErr              (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks;
  int         n_errors;
  bit         exp_err;
  int         req_cnt;
  int         tx_cnt;
  logic [7:0] tx_log [0:255];

  // Handshake monitor: counts requests and logs every accepted TX byte.
  always @(posedge clk) begin
    if (!rst && req_valid && req_ready) req_cnt++;
    if (!rst && tx_valid && tx_ready) begin
      tx_log[tx_cnt[7:0]] = tx_byte;
      tx_cnt++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic logic [31:0] be_word(input logic [7:0] q[$], input int off);
    return (32'(q[off]) << 24) | (32'(q[off+1]) << 16) | (32'(q[off+2]) << 8) | 32'(q[off+3]);
  endfunction

  // Sends a whole frame, drives the request handshake and, for reads, the response and TX drain.
  task automatic run_frame(input logic [7:0] q[$], input int stall, input bit toggle_tx,
                           input logic [31:0] rdata, input bit junk, input int long_gap_at);
    int          base_req;
    int          base_tx;
    bit          is_wr;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [31:0] sh;
    is_wr    = (q[0] == 8'h57);
    e_addr   = be_word(q, 1);
    e_data   = is_wr ? be_word(q, 5) : 32'd0;
    base_req = req_cnt;
    base_tx  = tx_cnt;
    for (int i = 0; i < q.size(); i++) begin
      if (i == long_gap_at) repeat (ByteTmo + 5) tick();
      send_byte(q[i], (i == q.size() - 1) ? 0 : int'($urandom_range(0, 2)));
    end
    check_eq("req_valid_latency", 32'(req_valid), 32'd1);
    for (int s = 0; s < stall; s++) begin
      check_eq("req_hold_valid", 32'(req_valid), 32'd1);
      check_eq("req_hold_addr", req_addr, e_addr);
      check_eq("req_hold_data", req_data, e_data);
      rx_valid = (s == 1);
      rx_byte  = 8'h57;
      tick();
      rx_valid = 1'b0;
    end
    check_eq("req_op", 32'(req_op), is_wr ? 32'(WR) : 32'(RD));
    check_eq("req_addr", req_addr, e_addr);
    check_eq("req_data", req_data, e_data);
    check_eq("req_tid", 32'(req_tid), 32'(Tid));
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check_eq("req_count", 32'(req_cnt - base_req), 32'd1);
    check_eq("req_drop", 32'(req_valid), 32'd0);
    if (is_wr) begin
      repeat (3) tick();
      check_eq("wr_no_tx", 32'(tx_cnt - base_tx), 32'd0);
    end else begin
      repeat ($urandom_range(0, 4)) tick();
      if (junk) begin
        rsp_valid = 1'b1; rsp_op = RD_RSP; rsp_tid = ~Tid; rsp_data = $urandom;
        rx_valid = 1'b1; rx_byte = 8'h52;
        tick();
        rx_valid = 1'b0;
        rsp_op = WR; rsp_tid = Tid;
        tick();
        rsp_valid = 1'b0;
        tick();
        check_eq("junk_rsp_ignored", 32'(tx_valid), 32'd0);
      end
      tx_ready  = 1'b0;
      rsp_valid = 1'b1; rsp_op = RD_RSP; rsp_tid = Tid; rsp_data = rdata;
      tick();
      rsp_valid = 1'b0;
      check_eq("tx_valid_latency", 32'(tx_valid), 32'd1);
      check_eq("tx_first_byte", 32'(tx_byte), 32'(rdata[31:24]));
      for (int k = 0; k < 200 && (tx_cnt - base_tx) < 4; k++) begin
        tx_ready = toggle_tx ? (k % 2 == 0) : 1'($urandom);
        tick();
      end
      tx_ready = 1'b0;
      check_eq("tx_count", 32'(tx_cnt - base_tx), 32'd4);
      for (int j = 0; j < 4; j++) begin
        sh = rdata >> (24 - 8 * j);
        check_eq($sformatf("tx_byte%0d", j), 32'(tx_log[(base_tx + j) % 256]), 32'(sh[7:0]));
      end
      tx_ready = 1'b1;
      repeat (3) tick();
      tx_ready = 1'b0;
      check_eq("tx_no_extra", 32'(tx_cnt - base_tx), 32'd4);
      check_eq("tx_idle", 32'(tx_valid), 32'd0);
    end
    check_eq("cmd_err", 32'(cmd_err), 32'(exp_err));
  endtask

  function automatic void make_frame(input bit is_wr, output logic [7:0] q[$]);
    q = {};
    q.push_back(is_wr ? 8'h57 : 8'h52);
    for (int i = 0; i < (is_wr ? 8 : 4); i++) q.push_back(8'($urandom));
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic run_rsp_timeout();
    logic [7:0] q[$];
    int         base_tx;
    int         i;
    make_frame(1'b0, q);
    base_tx = tx_cnt;
    for (int b = 0; b < q.size(); b++) send_byte(q[b], 0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    for (i = 1; i <= int'(RspTmo) + 10; i++) begin
      rsp_valid = (i == 3); rsp_op = RD_RSP; rsp_tid = ~Tid; rsp_data = 32'hCAFEF00D;
      tick();
      rsp_valid = 1'b0;
      if (cmd_err) break;
    end
    check_eq($sformatf("rsp_tmo_at_cycle_%0d", i),
             32'(i >= int'(RspTmo) && i <= int'(RspTmo) + 1), 32'd1);
    check_eq("rsp_tmo_no_tx", 32'(tx_cnt - base_tx), 32'd0);
    exp_err = 1'b1;
  endtask

  initial begin
    logic [7:0] q[$];
    int         base_req;
    n_checks = 0; n_errors = 0; exp_err = 1'b0; req_cnt = 0; tx_cnt = 0;
    rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'd0; tx_ready = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_op = NOP; rsp_tid = 2'd0; rsp_data = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_tx_byte", 32'(tx_byte), 32'd0);
    check_eq("rst_req_valid", 32'(req_valid), 32'd0);
    check_eq("rst_req_op", 32'(req_op), 32'd0);
    check_eq("rst_req_addr", req_addr, 32'd0);
    check_eq("rst_req_data", req_data, 32'd0);
    check_eq("rst_req_tid", 32'(req_tid), 32'd0);
    check_eq("rst_cmd_err", 32'(cmd_err), 32'd0);

    q = {8'h57, 8'h00, 8'h00, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(q, 0, 1'b0, 32'd0, 1'b0, -1);
    q = {8'h52, 8'h00, 8'h00, 8'h20, 8'h00};
    run_frame(q, 5, 1'b1, 32'h12345678, 1'b0, -1);

    for (int n = 0; n < 10; n++) begin
      make_frame(1'($urandom), q);
      run_frame(q, int'($urandom_range(0, 4)), 1'b0, $urandom, 1'($urandom), -1);
    end

    run_rsp_timeout();
    make_frame(1'b1, q);
    run_frame(q, 1, 1'b0, 32'd0, 1'b0, -1);

    pulse_reset();
    base_req = req_cnt;
    make_frame(1'b1, q);
    for (int b = 0; b < 4; b++) send_byte(q[b], 0);
    pulse_reset();
    check_eq("abort_req_valid", 32'(req_valid), 32'd0);
    check_eq("abort_req_addr", req_addr, 32'd0);
    repeat (5) tick();
    check_eq("abort_no_req", 32'(req_cnt - base_req), 32'd0);
    make_frame(1'b1, q);
    run_frame(q, 2, 1'b0, 32'd0, 1'b0, -1);

    base_req = req_cnt;
    send_byte(8'h41, 2);
    check_eq("bad_cmd_err", 32'(cmd_err), 32'd1);
    check_eq("bad_cmd_no_req", 32'(req_cnt - base_req), 32'd0);
    exp_err = 1'b1;
    make_frame(1'b0, q);
    run_frame(q, 0, 1'b0, $urandom, 1'b0, -1);

    pulse_reset();
    base_req = req_cnt;
`ifdef UART_CMD_BYTE_TMO_EN
    send_byte(8'h57, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    repeat (ByteTmo + 5) tick();
    check_eq("byte_tmo_err", 32'(cmd_err), 32'd1);
    check_eq("byte_tmo_no_req", 32'(req_cnt - base_req), 32'd0);
    exp_err = 1'b1;
    make_frame(1'b1, q);
    run_frame(q, 0, 1'b0, 32'd0, 1'b0, -1);
`else
    make_frame(1'b1, q);
    run_frame(q, 0, 1'b0, 32'd0, 1'b0, 3);
    check_eq("stall_frame_req", 32'(req_cnt - base_req), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
